// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESUME} dc_state_t;

  localparam int DC_LINES      = 16;
  localparam int DC_LINE_WORDS = 4;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return 32 - idx_w(lines) - off_w(line_words) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one combinational read port, a line-fill write port
// and a store write port that only updates a line already holding the tag.
module dcache_array import dcache_pkg::*; #(
  parameter int LINES      = DC_LINES,
  parameter int LINE_WORDS = DC_LINE_WORDS,
  localparam int OFF_W     = off_w(LINE_WORDS),
  localparam int IDX_W     = idx_w(LINES),
  localparam int TAG_W     = tag_w(LINES, LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_data,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             fill_en,
  input  logic             fill_last,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [OFF_W-1:0] fill_off,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             st_en,
  input  logic [IDX_W-1:0] st_idx,
  input  logic [OFF_W-1:0] st_off,
  input  logic [TAG_W-1:0] st_tag,
  input  logic [31:0]      st_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];
  logic [31:0]      data_d [LINES][LINE_WORDS];
  logic             st_hit;

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx][rd_off];
  assign st_hit  = valid_q[st_idx] && (tag_q[st_idx] == st_tag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_en) valid_d[inv_idx] = 1'b0;
    if (fill_en) begin
      data_d[fill_idx][fill_off] = fill_data;
      // Line becomes visible only once its last beat has landed.
      if (fill_last) begin
        tag_d[fill_idx]   = fill_tag;
        valid_d[fill_idx] = 1'b1;
      end
    end
    if (st_en && st_hit) data_d[st_idx][st_off] = st_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int LINES      = DC_LINES,
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, LINE_WORDS);
  localparam int TAG_LO = OFF_W + IDX_W + 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  dc_state_t        state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [OFF_W-1:0] beat_q, beat_d;

  logic             rd_hit;
  logic             inv_en, fill_en, fill_last, st_en;
  logic             unused_addr_bits;

  // Request fields come from the held pipeline address; memory-side fields
  // come from the latched beat address so they cannot drift mid-transfer.
  logic [OFF_W-1:0] req_off, mem_off;
  logic [IDX_W-1:0] req_idx, mem_idx;
  logic [TAG_W-1:0] req_tag, mem_tag;

  assign req_off = d_addr[OFF_W+1:2];
  assign req_idx = d_addr[TAG_LO-1:OFF_W+2];
  assign req_tag = d_addr[31:TAG_LO];
  assign mem_off = mem_addr_q[OFF_W+1:2];
  assign mem_idx = mem_addr_q[TAG_LO-1:OFF_W+2];
  assign mem_tag = mem_addr_q[31:TAG_LO];
  assign unused_addr_bits = ^d_addr[1:0];

  dcache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_idx),
    .rd_off    (req_off),
    .rd_tag    (req_tag),
    .rd_hit    (rd_hit),
    .rd_data   (d_rd_data),
    .inv_en    (inv_en),
    .inv_idx   (req_idx),
    .fill_en   (fill_en),
    .fill_last (fill_last),
    .fill_idx  (mem_idx),
    .fill_off  (beat_q),
    .fill_tag  (mem_tag),
    .fill_data (mem_rdata),
    .st_en     (st_en),
    .st_idx    (mem_idx),
    .st_off    (mem_off),
    .st_tag    (mem_tag),
    .st_data   (mem_wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    beat_d      = beat_q;
    d_miss      = 1'b0;
    inv_en      = 1'b0;
    fill_en     = 1'b0;
    fill_last   = 1'b0;
    st_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_wr) begin
          d_miss      = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {d_addr[31:2], 2'b00};
          mem_wdata_d = d_wr_data;
          state_d     = WRITE;
        end else if (d_rd && !rd_hit) begin
          // Old contents of this index are overwritten beat by beat, so the
          // line is dropped now; an aborted fill then leaves it invalid.
          d_miss     = 1'b1;
          inv_en     = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {d_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          beat_d     = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        d_miss = 1'b1;
        if (mem_gnt) begin
          fill_en    = 1'b1;
          beat_d     = beat_q + OFF_W'(1);
          mem_addr_d = mem_addr_q + 32'd4;
          if (beat_q == LAST_BEAT) begin
            fill_last = 1'b1;
            mem_req_d = 1'b0;
            state_d   = RESUME;
          end
        end
      end
      WRITE: begin
        d_miss = 1'b1;
        if (mem_gnt) begin
          st_en     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESUME;
        end
      end
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      beat_q      <= beat_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == IDLE) && !d_wr && d_rd && rd_hit;
  assign miss_evt = (state_q == IDLE) && !d_wr && d_rd && !rd_hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then randomized
// traffic against a line-residency model and a behavioural backing memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_addr = '0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_wr_data = '0;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .d_addr    (d_addr),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_wr_data (d_wr_data),
    .d_rd_data (d_rd_data),
    .d_miss    (d_miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: explicit contents where written/preloaded, a fixed
  // address-derived pattern elsewhere.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t beat_log[$];

  int          fixed_delay = 0;
  bit          rand_mode   = 1'b0;
  int          cur_delay   = 0;
  int          wait_cnt    = 0;
  int          req_cycles  = 0;
  bit          prev_wait   = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  // Memory responder: grants after cur_delay waiting cycles and checks the
  // request stays frozen while it waits.
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      req_cycles++;
      if (prev_wait) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", 32'(mem_we), 32'(prev_we));
        if (mem_we) chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (wait_cnt >= cur_delay) begin
        mem_gnt   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        beat_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
        wait_cnt  = 0;
        prev_wait = 1'b0;
        cur_delay = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
      end else begin
        mem_gnt    = 1'b0;
        mem_rdata  = $urandom;
        wait_cnt++;
        prev_wait  = 1'b1;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end
    end else begin
      mem_gnt   = 1'b0;
      wait_cnt  = 0;
      prev_wait = 1'b0;
      cur_delay = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
    end
  end

  // Reference model: which line number (addr >> 4) each of the 16 sets holds.
  bit          m_valid [16];
  logic [31:0] m_line  [16];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic access(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_miss_cycles);
    logic [31:0] line;
    int          idx;
    bit          exp_hit;
    bit          done;
    int          miss_cycles;
    line    = addr >> 4;
    idx     = int'(line & 32'd15);
    exp_hit = !wr && m_valid[idx] && (m_line[idx] == line);
    beat_log.delete();
    req_cycles = 0;
    @(posedge clk); #1;
    d_addr = addr; d_rd = !wr; d_wr = wr; d_wr_data = wdata;
    @(negedge clk);
    chk(wr ? "wr_miss_flag" : "rd_miss_flag", 32'(d_miss), 32'(!exp_hit));
    if (exp_hit) begin
      chk("hit_data", d_rd_data, mem_rd(addr));
      exp_hits++;
    end else begin
      done = 1'b0;
      miss_cycles = 1;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (!d_miss) done = 1'b1;
        else miss_cycles++;
      end
      chk("complete", 32'(done), 32'd1);
      if (exp_miss_cycles >= 0) chk("miss_cycles", miss_cycles, exp_miss_cycles);
      if (wr) begin
        chk("wr_beats", beat_log.size(), 1);
        if (beat_log.size() >= 1) begin
          chk("wr_we", 32'(beat_log[0].we), 32'd1);
          chk("wr_addr", beat_log[0].addr, {addr[31:2], 2'b00});
          chk("wr_data", beat_log[0].data, wdata);
        end
      end else begin
        chk("fill_data", d_rd_data, mem_rd(addr));
        chk("fill_beats", beat_log.size(), 4);
        for (int i = 0; i < beat_log.size() && i < 4; i++) begin
          chk("fill_we", 32'(beat_log[i].we), 32'd0);
          chk("fill_addr", beat_log[i].addr, (line << 4) + 32'(4 * i));
        end
        m_valid[idx] = 1'b1;
        m_line[idx]  = line;
        exp_misses++;
      end
    end
    @(posedge clk); #1;
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 4; i++) mem[32'h40 + 32'(4 * i)] = 32'h1000 + 32'(i);
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_line[i] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_d_miss", 32'(d_miss), 32'd0);
    rst = 1'b0;

    // Cold fill then same-line hit.
    access(1'b0, 32'h40, 32'h0, 5);
    chk("cold_word0", d_rd_data, 32'h1000);
    access(1'b0, 32'h44, 32'h0, -1);

    // Write hit with a slow grant, then read back.
    fixed_delay = 3;
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 5);
    chk("wr_req_cycles", req_cycles, 4);
    fixed_delay = 0;
    access(1'b0, 32'h44, 32'h0, -1);

    // Write miss does not allocate.
    access(1'b1, 32'h200, 32'h1234_5678, -1);
    access(1'b0, 32'h200, 32'h0, 5);

    // Aliasing on set 4.
    access(1'b0, 32'h440, 32'h0, 5);
    access(1'b0, 32'h40, 32'h0, 5);

    // Reset in the middle of a fill.
    beat_log.delete();
    @(posedge clk); #1;
    d_addr = 32'h380; d_rd = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (beat_log.size() >= 2) done = 1'b1;
    end
    chk("fill_progress", 32'(done), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    d_rd = 1'b0;
    @(negedge clk);
    chk("abort_idle_miss", 32'(d_miss), 32'd0);
    #2 rst = 1'b0;
    m_valid[8] = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_hits = 0; exp_misses = 0;
    access(1'b0, 32'h384, 32'h0, 5);
    access(1'b0, 32'h380, 32'h0, -1);

    // Randomized traffic over 4 tags x 16 sets with random grant delays.
    rand_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 9) < 3) access(1'b1, a, $urandom, -1);
      else                          access(1'b0, a, 32'h0, -1);
    end
    rand_mode = 1'b0;

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    access(1'b0, 32'h384, 32'h0, -1);
    access(1'b0, 32'h384, 32'h0, -1);
    @(negedge clk);
    chk("hit_cnt_sat", hit_cnt, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-side cache controller directly downstream of the memory-access stage.
- Consumes that stage's d_rd / d_wr / d_wr_data / address, returns read data, and drives d_miss back to stall the pipeline.
- Direct-mapped, write-through, read-allocate / no-write-allocate cache over a single-beat backing-memory port.
- Shared by all 8 hardware threads; one request serviced at a time.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
d_addr  in  32  byte address from memory stage; bits [1:0] ignored
d_rd  in  1  read request (already gated by stage flush)
d_wr  in  1  write request (already gated by stage flush)
d_wr_data  in  32  store data
d_rd_data  out  32  load data, valid when d_rd & !d_miss
d_miss  out  1  stall: pipeline holds d_addr/d_rd/d_wr/d_wr_data stable while high
mem_req  out  1  backing-memory beat request
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  32  word-aligned beat address
mem_wdata  out  32  write beat data
mem_gnt  in  1  beat accepted this cycle; for reads, mem_rdata valid same cycle
mem_rdata  in  32  read beat data

Behaviour:
- Address split:
  - offset = d_addr[OFF+1:2], OFF = log2(LINE_WORDS).
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: flop arrays data[LINES][LINE_WORDS], tag[LINES], valid[LINES]. Reset clears valid only.
- FSM states: IDLE, FILL, WRITE, RESUME. Reset -> IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, beat counter=0, d_miss=0.
- IDLE, read hit (valid & tag match): d_rd_data = data[index][offset] combinationally; d_miss=0; zero added latency.
- IDLE, read miss:
  - d_miss=1 combinationally the same cycle.
  - Latch line base address; beat=0; -> FILL.
- IDLE, d_wr (hit or miss):
  - d_miss=1.
  - Latch address/data -> WRITE.
  - d_wr has priority if d_rd & d_wr are both set (illegal; bench flags it).
- FILL:
  - mem_req=1, mem_we=0, mem_addr = base + beat*4.
  - On mem_gnt: data[index][beat] <= mem_rdata; beat++.
  - On last beat's gnt: tag <= tag, valid <= 1 -> RESUME.
  - d_miss=1 throughout.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata from latched values; hold until mem_gnt.
  - On gnt: if the line hits, update the cached word (no allocate on miss) -> RESUME.
  - d_miss=1 throughout.
- RESUME:
  - d_miss=0 for exactly one cycle. A read serves from the now-valid line; a write is complete.
  - No new request is accepted this cycle -> IDLE.
- mem_req stays asserted until gnt; address and data never change while mem_req=1 and gnt=0.
- Beat counter is log2(LINE_WORDS) bits and wraps only at the FILL exit.
- Reset mid-FILL/WRITE: mem_req drops immediately (async), the partially filled line stays invalid, FSM returns to IDLE; the in-flight memory beat is abandoned.
- Index aliasing: a fill to the same index replaces the old tag; no writeback is needed (write-through).

Optional Feature:
- Macro DCACHE_STATS_EN adds outputs hit_cnt[31:0] and miss_cnt[31:0]. Both are reset to 0 and saturate at 0xFFFFFFFF.
  - hit_cnt increments on each IDLE read hit.
  - miss_cnt increments on each IDLE->FILL transition.
  - Writes are not counted.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - FSM state enum dc_state_t {IDLE, FILL, WRITE, RESUME}.
  - Default LINES / LINE_WORDS constants.
  - Width helpers OFF_W, IDX_W, TAG_W.
- One natural sub-module: dcache_array (tag/valid/data storage with a read port, a fill-write port and a store-write port). The FSM and memory port stay in dcache_ctrl.

Test Plan:
- Cold read 0x0000_0040, memory gnt every cycle with data 0x1000+beat -> d_miss high 5 cycles (4 beats + RESUME low), d_rd_data=0x1000; re-read 0x0000_0044 -> hit, d_rd_data=0x1001, d_miss=0.
- Write hit 0x44 data 0xDEAD_BEEF, gnt delayed 3 cycles -> mem_req/mem_we held 4 cycles with stable addr 0x44; then read 0x44 -> hit returns 0xDEAD_BEEF.
- Write miss 0x200 -> memory write issued, valid[index] unchanged; subsequent read 0x200 misses and fills.
- Aliasing: fill 0x040, then read 0x440 (same index, LINES=16, LINE_WORDS=4) -> refill; read 0x040 misses again.
- Assert rst during beat 2 of a fill -> mem_req=0 the same cycle, FSM IDLE; re-read the same address -> full 4-beat fill again.
- With DCACHE_STATS_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; force hit_cnt=0xFFFF_FFFF and hit again -> stays 0xFFFF_FFFF.
